countdown_scheduler: RTL and testbench
======================================

Name: countdown_scheduler

Overview:
- Multi-channel countdown controller built around one shared WIDTH-bit decrement unit (out = in - 1, modulo 2^WIDTH).
- NCH independent countdown channels share that unit round-robin, at most one channel decremented per enabled cycle.
- Sits between software/FSM loaders and downstream timeout logic; reports per-channel count, busy and done.

Parameters:
- NCH, 4, number of countdown channels (2..8).
- WIDTH, 4, count width per channel in bits.
- PW, 2, pointer/grant index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- tick  input  1  service enable; a decrement slot exists only in cycles with tick=1.
- ld_en  input  NCH  per-channel load strobe.
- ld_val  input  NCH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- stop  input  NCH  per-channel cancel.
- count  output  NCH*WIDTH  current count per channel, same packing as ld_val.
- busy  output  NCH  channel active, i.e. count still running.
- done  output  NCH  one-cycle pulse when channel reaches 0 by decrement or by zero load.
- gnt_valid  output  1  a decrement was performed this edge.
- gnt_ch  output  PW  channel decremented this edge; holds its last value when gnt_valid=0.

Behaviour:
- Reset (rst_n low, async): count=0, busy=0, done=0, gnt_valid=0, gnt_ch=0, rr pointer=0. Takes effect immediately, including mid-countdown. No done is generated by reset.
- All outputs are registered.
- Eligibility per cycle:
  - channel i is eligible if busy[i]=1, ld_en[i]=0 and stop[i]=0, all sampled before the edge.
  - If tick=1 and at least one channel is eligible, grant the first eligible channel searching cyclically from ptr (ptr, ptr+1, ..., wrap to 0).
  - On a grant: ptr <= grant+1 mod NCH, gnt_valid <= 1, gnt_ch <= grant.
  - Otherwise gnt_valid <= 0 and ptr is unchanged.
- Decrement: count[g] <= count[g]-1 through the shared unit.
  - If the result is 0: busy[g] <= 0 and done[g] <= 1 for one cycle.
  - A busy channel always has count >= 1, so 0 -> all-ones wrap never occurs.
- Load (ld_en[i]=1):
  - count[i] <= ld_val[i].
  - If ld_val != 0: busy[i] <= 1.
  - If ld_val == 0: busy[i] <= 0 and done[i] <= 1 on that edge.
  - Load has priority over stop and over decrement; a loading channel is never granted that cycle.
  - Reloading an active channel restarts it with no done for the aborted run.
- Stop (stop[i]=1, ld_en[i]=0): busy[i] <= 0, count[i] holds its value, no done. Stop on an idle channel has no effect.
- done[i] defaults to 0 every cycle unless set by the rules above. Done pulses on several channels in the same cycle are permitted.
- Latency:
  - load V (V>=1) with a single active channel and tick held high: done rises V edges after the load edge.
  - With k channels continuously active, each channel is serviced once every k ticks.
- Unused pointer codes when NCH is not a power of 2: pointer wraps explicitly at NCH-1 -> 0.

Optional Feature:
- Macro: COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN.
- Defined:
  - Add input reload_en[NCH]; each channel stores its last nonzero ld_val in a reload register (reset 0).
  - When a decrement reaches 0 and reload_en[i]=1: done[i] pulses, count[i] <= reload register, busy[i] stays 1 (periodic mode).
  - Zero load and stop behave as in the base spec; stop clears busy even in reload mode.
- Undefined: the reload_en port and reload registers do not exist; every channel is one-shot as described above.

Test Plan:
- Reset: drive activity, assert rst_n=0 mid-count at an arbitrary phase -> all count=0, busy=0, done=0, gnt_valid=0 before the next clock edge. Release -> idle.
- Single channel, NCH=4/WIDTH=4: ld_en[0] with ld_val=3, tick=1 continuously -> count[0] follows 3,2,1,0 on successive edges, gnt_ch=0 each time, done[0]=1 for exactly one cycle coincident with count=0, busy[0] falls on the same edge.
- Round-robin: load ch0=2 and ch2=2 on the same edge, tick=1 -> grants 0,2,0,2; done[0] one cycle before done[2]. Toggling tick 1,0,1,0 halves the rate, and gnt_valid=0 in the tick=0 cycles.
- Load collision: ch1 active at count 5 while ch3 is also active, assert ld_en[1] with ld_val=9 in a cycle where ptr=1 -> count[1]=9, ch3 granted instead, no done[1].
- Zero load and stop: ld_en[2] with ld_val=0 -> done[2] pulses, busy[2]=0, no grant to ch2. Load ch1=7, stop[1] after 2 decrements -> count[1]=5 held, busy[1]=0, no done[1].
- With COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN defined: load ch0=2 with reload_en[0]=1 and tick held high -> done[0] every 2 edges with count[0] sequence 2,1,2,1,...; stop[0] ends the sequence with no further done.

Source files
------------

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: NCH countdown channels sharing one WIDTH-bit decrementer,
// serviced round-robin on tick cycles. Reports per-channel count/busy/done.
// Optional feature: define COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN to add per-channel
// periodic reload (reload_en input plus a reload register per channel).
module countdown_scheduler #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [NCH-1:0]        ld_en,
    input  logic [NCH*WIDTH-1:0]  ld_val,
    input  logic [NCH-1:0]        stop,
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
    input  logic [NCH-1:0]        reload_en,
`endif
    output logic [NCH*WIDTH-1:0]  count,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic                  gnt_valid,
    output logic [PW-1:0]         gnt_ch
);

    localparam int unsigned LAST_CH = NCH - 1;

    logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
    logic [NCH-1:0]            busy_q, busy_d;
    logic [NCH-1:0]            done_q, done_d;
    logic                      gnt_valid_q, gnt_valid_d;
    logic [PW-1:0]             gnt_ch_q, gnt_ch_d;
    logic [PW-1:0]             ptr_q, ptr_d;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
    logic [NCH-1:0][WIDTH-1:0] reload_q, reload_d;
`endif

    logic [NCH-1:0]   elig_c;
    logic             found_c;
    logic [PW-1:0]    grant_c;
    logic [PW-1:0]    scan_idx_c;
    logic [WIDTH-1:0] dec_out_c;

    // Cyclic successor; wraps explicitly so unused codes are never reached.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
        return (x == PW'(LAST_CH)) ? '0 : x + PW'(1);
    endfunction

    // Round-robin arbiter over eligible channels, starting at ptr.
    always_comb begin
        elig_c     = busy_q & ~ld_en & ~stop;
        found_c    = 1'b0;
        grant_c    = '0;
        scan_idx_c = ptr_q;
        for (int k = 0; k < int'(NCH); k++) begin
            if (tick && !found_c && elig_c[scan_idx_c]) begin
                found_c = 1'b1;
                grant_c = scan_idx_c;
            end
            scan_idx_c = next_idx(scan_idx_c);
        end
    end

    // The single shared decrement unit.
    always_comb dec_out_c = count_q[grant_c] - WIDTH'(1);

    // Next-state: load beats stop beats decrement.
    always_comb begin
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = '0;
        gnt_valid_d = found_c;
        gnt_ch_d    = found_c ? grant_c : gnt_ch_q;
        ptr_d       = found_c ? next_idx(grant_c) : ptr_q;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
        reload_d    = reload_q;
`endif
        for (int i = 0; i < int'(NCH); i++) begin
            if (ld_en[i]) begin
                count_d[i] = ld_val[i*WIDTH +: WIDTH];
                if (ld_val[i*WIDTH +: WIDTH] != '0) begin
                    busy_d[i] = 1'b1;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
                    reload_d[i] = ld_val[i*WIDTH +: WIDTH];
`endif
                end else begin
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end
            end else if (stop[i]) begin
                busy_d[i] = 1'b0;
            end else if (found_c && (grant_c == PW'(i))) begin
                count_d[i] = dec_out_c;
                if (dec_out_c == '0) begin
                    done_d[i] = 1'b1;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
                    if (reload_en[i]) begin
                        count_d[i] = reload_q[i];
                    end else begin
                        busy_d[i] = 1'b0;
                    end
`else
                    busy_d[i] = 1'b0;
`endif
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            gnt_valid_q <= 1'b0;
            gnt_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
            reload_q    <= '0;
`endif
        end else begin
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_ch_q    <= gnt_ch_d;
            ptr_q       <= ptr_d;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
            reload_q    <= reload_d;
`endif
        end
    end

    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_ch    = gnt_ch_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Bench for countdown_scheduler (NCH=4, WIDTH=4): scoreboard of expected
// per-cycle outputs from a behavioural model, plus directed point checks.
module tb_countdown_scheduler;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic [3:0]  ld_en;
    logic [15:0] ld_val;
    logic [3:0]  stop;
    logic [3:0]  reload_en;
    logic [15:0] count;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic        gnt_valid;
    logic [1:0]  gnt_ch;

    countdown_scheduler #(.NCH(4), .WIDTH(4), .PW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .ld_en     (ld_en),
        .ld_val    (ld_val),
        .stop      (stop),
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
        .reload_en (reload_en),
`endif
        .count     (count),
        .busy      (busy),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic [3:0]  bsy;
        logic [3:0]  dn;
        logic        gv;
        logic [1:0]  gch;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [3:0] m_cnt[4];
    logic [3:0] m_rel[4];
    bit         m_busy[4];
    bit         m_done[4];
    int         m_ptr;
    bit         m_gv;
    int         m_gch;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 4'd0; m_rel[i] = 4'd0; m_busy[i] = 0; m_done[i] = 0;
        end
        m_ptr = 0; m_gv = 0; m_gch = 0;
        q.delete();
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        bit el[4];
        int g;
        logic [3:0] v;
        exp_t e;
        g = -1;
        for (int i = 0; i < 4; i++) el[i] = m_busy[i] && !ld_en[i] && !stop[i];
        if (tick) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (g < 0 && el[c]) g = c;
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_done[i] = 0;
            if (ld_en[i]) begin
                v = ld_val[i*4 +: 4];
                m_cnt[i] = v;
                if (v != 0) begin
                    m_busy[i] = 1; m_rel[i] = v;
                end else begin
                    m_busy[i] = 0; m_done[i] = 1;
                end
            end else if (stop[i]) begin
                m_busy[i] = 0;
            end else if (i == g) begin
                m_cnt[i] = m_cnt[i] - 4'd1;
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1;
`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
                    if (reload_en[i]) m_cnt[i] = m_rel[i];
                    else m_busy[i] = 0;
`else
                    m_busy[i] = 0;
`endif
                end
            end
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % 4; m_gv = 1; m_gch = g;
        end else begin
            m_gv = 0;
        end
        for (int i = 0; i < 4; i++) begin
            e.cnt[i*4 +: 4] = m_cnt[i];
            e.bsy[i] = m_busy[i];
            e.dn[i]  = m_done[i];
        end
        e.gv  = m_gv;
        e.gch = 2'(m_gch);
        q.push_back(e);
    endtask

    // One clock: record expectation, clock the DUT, compare just after the edge.
    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check("sb_count", 32'(count), 32'(e.cnt));
            check("sb_busy", 32'(busy), 32'(e.bsy));
            check("sb_done", 32'(done), 32'(e.dn));
            check("sb_gnt_valid", 32'(gnt_valid), 32'(e.gv));
            if (e.gv) check("sb_gnt_ch", 32'(gnt_ch), 32'(e.gch));
        end
    endtask

    task automatic set_load(input int ch, input logic [3:0] v);
        ld_en[ch] = 1'b1;
        ld_val[ch*4 +: 4] = v;
    endtask

    task automatic clear_in();
        ld_en = '0; stop = '0;
    endtask

    task automatic do_reset();
        clear_in();
        tick = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    logic [1:0] rr_exp[4];

    initial begin
        rst_n = 1'b0; tick = 1'b0; ld_en = '0; ld_val = '0; stop = '0; reload_en = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        check("rst_gnt_ch", 32'(gnt_ch), 32'd0);

        // Asynchronous reset in the middle of a countdown.
        set_load(0, 4'd9); set_load(3, 4'd6); tick = 1'b1;
        step(); clear_in();
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Single channel: 3,2,1,0 with done on the last edge.
        set_load(0, 4'd3); tick = 1'b1;
        step(); clear_in();
        check("single_load_cnt", 32'(count[3:0]), 32'd3);
        check("single_load_busy", 32'(busy[0]), 32'd1);
        for (int v = 2; v >= 0; v--) begin
            step();
            check("single_cnt", 32'(count[3:0]), 32'(v));
            check("single_gnt_ch", 32'(gnt_ch), 32'd0);
            check("single_done", 32'(done[0]), (v == 0) ? 32'd1 : 32'd0);
            check("single_busy", 32'(busy[0]), (v == 0) ? 32'd0 : 32'd1);
        end
        step();
        check("single_done_once", 32'(done[0]), 32'd0);
        check("single_idle_gv", 32'(gnt_valid), 32'd0);

        // Round robin between ch0 and ch2, then half-rate tick.
        do_reset();
        rr_exp[0] = 2'd0; rr_exp[1] = 2'd2; rr_exp[2] = 2'd0; rr_exp[3] = 2'd2;
        set_load(0, 4'd2); set_load(2, 4'd2); tick = 1'b1;
        step(); clear_in();
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt_ch", 32'(gnt_ch), 32'(rr_exp[k]));
            if (k == 2) check("rr_done0", 32'(done), 32'b0001);
            if (k == 3) check("rr_done2", 32'(done), 32'b0100);
        end
        set_load(0, 4'd2); set_load(2, 4'd2);
        step(); clear_in();
        for (int k = 0; k < 8; k++) begin
            tick = (k % 2 == 0);
            step();
            check("half_rate_gv", 32'(gnt_valid), 32'(k % 2 == 0));
        end

        // Load collision on the channel the pointer addresses.
        do_reset();
        set_load(0, 4'd1); set_load(1, 4'd5); set_load(3, 4'd9); tick = 1'b0;
        step(); clear_in();
        tick = 1'b1;
        step();
        check("coll_pre_gnt", 32'(gnt_ch), 32'd0);
        check("coll_pre_done", 32'(done[0]), 32'd1);
        set_load(1, 4'd9);
        step(); clear_in();
        check("coll_cnt1", 32'(count[7:4]), 32'd9);
        check("coll_gnt_ch", 32'(gnt_ch), 32'd3);
        check("coll_no_done1", 32'(done[1]), 32'd0);

        // Zero load on ch2.
        set_load(2, 4'd0);
        step(); clear_in();
        check("zero_done2", 32'(done[2]), 32'd1);
        check("zero_busy2", 32'(busy[2]), 32'd0);
        check("zero_gnt_ch", 32'(gnt_ch), 32'd1);

        // Stop after two decrements holds the count.
        do_reset();
        set_load(1, 4'd7); tick = 1'b1;
        step(); clear_in();
        repeat (2) step();
        stop = 4'b0011;
        step(); clear_in();
        check("stop_cnt1", 32'(count[7:4]), 32'd5);
        check("stop_busy1", 32'(busy[1]), 32'd0);
        check("stop_no_done", 32'(done), 32'd0);
        check("stop_gv", 32'(gnt_valid), 32'd0);

`ifdef COUNTDOWN_SCHEDULER_AUTO_RELOAD_EN
        // Periodic reload: 2,1,2,1,... with done on each reload.
        do_reset();
        reload_en = 4'b0001;
        set_load(0, 4'd2); tick = 1'b1;
        step(); clear_in();
        for (int k = 0; k < 6; k++) begin
            step();
            check("rel_cnt", 32'(count[3:0]), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rel_done", 32'(done[0]), (k % 2 == 0) ? 32'd0 : 32'd1);
            check("rel_busy", 32'(busy[0]), 32'd1);
        end
        stop = 4'b0001;
        step(); clear_in();
        check("rel_stop_busy", 32'(busy[0]), 32'd0);
        repeat (3) begin
            step();
            check("rel_stop_done", 32'(done[0]), 32'd0);
        end
        reload_en = '0;
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                ld_en[i] = ($urandom_range(7) == 0);
                stop[i]  = ($urandom_range(15) == 0);
            end
            ld_val    = 16'($urandom);
            tick      = ($urandom_range(3) != 0);
            reload_en = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
